// File: rtl/coord_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : coord_pkg                                                    |
// | Description : Shared definitions for the coordinate entry path: FSM state  |
// |               encodings and default coordinate geometry shared with the    |
// |               game controller.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package coord_pkg;

    // State encodings are visible on the state port, so they are fixed values.
    localparam logic [1:0] ENC_ENTER_X = 2'b00;
    localparam logic [1:0] ENC_ENTER_Y = 2'b01;
    localparam logic [1:0] ENC_READY   = 2'b10;
    localparam logic [1:0] ENC_COMMIT  = 2'b11;

    typedef enum logic [1:0] {
        ST_ENTER_X = ENC_ENTER_X,
        ST_ENTER_Y = ENC_ENTER_Y,
        ST_READY   = ENC_READY,
        ST_COMMIT  = ENC_COMMIT
    } coord_state_e;

    // Board geometry defaults, shared with the game controller.
    localparam int unsigned COORD_W_DEF    = 4;
    localparam int unsigned BOARD_MAX_DEF  = 9;
    localparam int unsigned DEB_CYCLES_DEF = 4;

endpackage : coord_pkg
`default_nettype wire

// File: rtl/coord_entry_handler_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : button_debounce                                              |
// | Description : Synchronises one active-low asynchronous push button and     |
// |               debounces it with a stable-count filter. Emits a one-cycle   |
// |               press pulse on the debounced released->pressed transition.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk    in  1  system clock                                               |
// |   reset  in  1  asynchronous active-low reset                              |
// |   btn_n  in  1  raw button, active low, asynchronous                       |
// |   press  out 1  one-cycle pulse, DEB_CYCLES+2 cycles after a clean press   |
// +----------------------------------------------------------------------------+
module button_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned       CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchroniser and accepted level reset to 1 so a reset never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // The synchronised level must differ from the accepted one for
            // DEB_CYCLES consecutive cycles; any agreeing cycle restarts the run.
            if (sync2_q != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_q <= sync2_q;
                    cnt_q    <= '0;
                    press_q  <= ~sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = press_q;

endmodule : button_debounce
`default_nettype wire

// File: rtl/coord_entry_handler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : coord_entry_handler                                          |
// | Description : Three-button coordinate entry. Debounced logic_0/logic_1     |
// |               presses are shifted into X then Y; an activity press range-  |
// |               checks and commits the pair (or aborts a partial entry).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk                 in  1        system clock                            |
// |   reset               in  1        asynchronous active-low reset           |
// |   logic_0_button      in  1        active-low, enters a 0 bit              |
// |   logic_1_button      in  1        active-low, enters a 1 bit              |
// |   activity_button     in  1        active-low, commit / abort              |
// |   x_counter           out CW       bits entered into X                     |
// |   y_counter           out CW       bits entered into Y                     |
// |   x_output            out COORD_W  last committed X                        |
// |   y_output            out COORD_W  last committed Y                        |
// |   valid_coordinate    out 1        pulse: legal pair committed             |
// |   invalid_coordinate  out 1        pulse: out-of-range pair rejected       |
// |   state               out 2        current FSM state                       |
// +----------------------------------------------------------------------------+
module coord_entry_handler
    import coord_pkg::*;
#(
    parameter int unsigned COORD_W    = COORD_W_DEF,
    parameter int unsigned BOARD_MAX  = BOARD_MAX_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter bit          MSB_FIRST  = 1'b0,
    localparam int unsigned CW        = $clog2(COORD_W + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               logic_0_button,
    input  logic               logic_1_button,
    input  logic               activity_button,
    output logic [CW-1:0]      x_counter,
    output logic [CW-1:0]      y_counter,
    output logic [COORD_W-1:0] x_output,
    output logic [COORD_W-1:0] y_output,
    output logic               valid_coordinate,
    output logic               invalid_coordinate,
    output logic [1:0]         state
);

    // Clamp the limit to the coordinate range so an oversized BOARD_MAX
    // simply accepts every pair instead of truncating to a wrong value.
    localparam int unsigned         ALL_ONES = (2 ** COORD_W) - 1;
    localparam int unsigned         LIMIT    = (BOARD_MAX >= ALL_ONES) ? ALL_ONES : BOARD_MAX;
    localparam logic [COORD_W-1:0]  C_MAX    = COORD_W'(LIMIT);
    localparam logic [CW-1:0]       C_LAST   = CW'(COORD_W - 1);

    logic [2:0]         w_btn_n;
    logic [2:0]         w_press;
    logic               w_bit_ev;
    logic               w_bit_val;
    logic               w_act;
    logic [COORD_W-1:0] w_x_next;
    logic [COORD_W-1:0] w_y_next;
    logic               w_in_range;

    coord_state_e       state_q;
    logic [COORD_W-1:0] x_shift_q;
    logic [COORD_W-1:0] y_shift_q;
    logic [CW-1:0]      x_cnt_q;
    logic [CW-1:0]      y_cnt_q;
    logic [COORD_W-1:0] x_out_q;
    logic [COORD_W-1:0] y_out_q;
    logic               valid_q;
    logic               invalid_q;

    assign w_btn_n = {activity_button, logic_1_button, logic_0_button};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        button_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .btn_n (w_btn_n[i]),
            .press (w_press[i])
        );
    end

    // Simultaneous 0 and 1 presses cancel; activity overrides any bit event
    // because the FSM tests it first.
    assign w_bit_ev  = w_press[0] ^ w_press[1];
    assign w_bit_val = w_press[1];
    assign w_act     = w_press[2];

    if (COORD_W == 1) begin : g_w1
        assign w_x_next = w_bit_val;
        assign w_y_next = w_bit_val;
    end else if (!MSB_FIRST) begin : g_lsb
        assign w_x_next = {w_bit_val, x_shift_q[COORD_W-1:1]};
        assign w_y_next = {w_bit_val, y_shift_q[COORD_W-1:1]};
    end else begin : g_msb
        assign w_x_next = {x_shift_q[COORD_W-2:0], w_bit_val};
        assign w_y_next = {y_shift_q[COORD_W-2:0], w_bit_val};
    end

    assign w_in_range = (x_shift_q <= C_MAX) && (y_shift_q <= C_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ENTER_X;
            x_shift_q <= '0;
            y_shift_q <= '0;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            x_out_q   <= '0;
            y_out_q   <= '0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            case (state_q)
                ST_ENTER_X, ST_ENTER_Y: begin
                    if (w_act) begin
                        // Abort the partial entry silently.
                        state_q   <= ST_ENTER_X;
                        x_shift_q <= '0;
                        y_shift_q <= '0;
                        x_cnt_q   <= '0;
                        y_cnt_q   <= '0;
                    end else if (w_bit_ev) begin
                        if (state_q == ST_ENTER_X) begin
                            x_shift_q <= w_x_next;
                            x_cnt_q   <= x_cnt_q + 1'b1;
                            if (x_cnt_q == C_LAST) begin
                                state_q <= ST_ENTER_Y;
                            end
                        end else begin
                            y_shift_q <= w_y_next;
                            y_cnt_q   <= y_cnt_q + 1'b1;
                            if (y_cnt_q == C_LAST) begin
                                state_q <= ST_READY;
                            end
                        end
                    end
                end
                ST_READY: begin
                    // Result is registered on entry so the pulse coincides
                    // with the single COMMIT cycle.
                    if (w_act) begin
                        state_q <= ST_COMMIT;
                        if (w_in_range) begin
                            x_out_q <= x_shift_q;
                            y_out_q <= y_shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            invalid_q <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q   <= ST_ENTER_X;
                    x_shift_q <= '0;
                    y_shift_q <= '0;
                    x_cnt_q   <= '0;
                    y_cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_ENTER_X;
                end
            endcase
        end
    end

    assign x_counter          = x_cnt_q;
    assign y_counter          = y_cnt_q;
    assign x_output           = x_out_q;
    assign y_output           = y_out_q;
    assign valid_coordinate   = valid_q;
    assign invalid_coordinate = invalid_q;
    assign state              = state_q;

endmodule : coord_entry_handler
`default_nettype wire
